pe_ctrl: RTL and testbench

- Sequences the parallel PE datapath (32-lane int16 multiplier + 32-input int32 adder tree) over dot products longer than one 32-element chunk.
- Accepts neuron/weight chunks over a valid/ready stream, multiplies them lane-wise, and reduces each chunk through the adder tree.
- Accumulates the per-chunk sums into a 32-bit result and presents it on a valid/ready output.
- Sits between the operand buffers and the output writeback in the parallel_pe hierarchy.

---
 rtl/pe_pkg.sv | 8 +
 rtl/pe_ctrl_if.sv | 22 ++
 rtl/pe_adder_tree.sv | 16 +
 rtl/pe_ctrl.sv | 85 ++++++++
 tb/tb_pe_ctrl.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared widths and FSM encoding for the parallel PE controller.
package pe_pkg;
   localparam int LANES  = 32;
   localparam int LANE_W = 16;
   localparam int PROD_W = 32;
   localparam int ACC_W  = 32;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;
endpackage

// File: rtl/pe_ctrl_if.sv
// pe_ctrl_if: job control, operand stream and result stream of the PE controller.
interface pe_ctrl_if #(parameter int CNT_W = 16);
   import pe_pkg::*;
   logic                      start;
   logic [CNT_W-1:0]          chunk_num;
   logic                      busy;
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*LANE_W-1:0]   neuron;
   logic [LANES*LANE_W-1:0]   weight;
   logic                      out_valid;
   logic                      out_ready;
   logic [ACC_W-1:0]          result;
   modport master (
      output start, chunk_num, in_valid, neuron, weight, out_ready,
      input  busy, in_ready, out_valid, result
   );
   modport slave (
      input  start, chunk_num, in_valid, neuron, weight, out_ready,
      output busy, in_ready, out_valid, result
   );
endinterface

// File: rtl/pe_adder_tree.sv
// pe_adder_tree: combinational 32-input wrapping reduction of the packed product bus.
module pe_adder_tree
   import pe_pkg::*;
(
   input  logic [LANES*PROD_W-1:0] prod,
   output logic [ACC_W-1:0]        sum
);
   logic [ACC_W-1:0] node [LANES];
   // Pairwise halving in place; node[i] only reads indices >= i, so nothing is clobbered early.
   always_comb begin
      for (int k = 0; k < LANES; k++) node[k] = prod[k*PROD_W +: PROD_W];
      for (int w = LANES / 2; w > 0; w = w / 2)
         for (int i = 0; i < w; i++) node[i] = node[2*i] + node[2*i+1];
      sum = node[0];
   end
endmodule

// File: rtl/pe_ctrl.sv
// pe_ctrl: sequences multi-chunk int16 dot products through lane multipliers and the adder tree.
module pe_ctrl
   import pe_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   pe_ctrl_if.slave    io
);
   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        remaining_q, remaining_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic [ACC_W-1:0]        psum_q, psum_d;
   logic                    psum_vld_q, psum_vld_d;
   logic [ACC_W-1:0]        result_q, result_d;
   logic [LANES*PROD_W-1:0] prod;
   logic [ACC_W-1:0]        chunk_sum;
   logic                    accept;
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [PROD_W-1:0] a, b;
      assign a = {{(PROD_W-LANE_W){io.neuron[k*LANE_W+LANE_W-1]}}, io.neuron[k*LANE_W +: LANE_W]};
      assign b = {{(PROD_W-LANE_W){io.weight[k*LANE_W+LANE_W-1]}}, io.weight[k*LANE_W +: LANE_W]};
      assign prod[k*PROD_W +: PROD_W] = a * b;
   end
   pe_adder_tree u_tree (
      .prod (prod),
      .sum  (chunk_sum)
   );
   assign accept       = io.in_valid && (state_q == RUN);
   assign io.in_ready  = state_q == RUN;
   assign io.busy      = state_q != IDLE;
   assign io.out_valid = state_q == OUT;
   assign io.result    = result_q;
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      result_d    = result_q;
      psum_vld_d  = accept;
      psum_d      = accept ? chunk_sum : psum_q;
      acc_d       = psum_vld_q ? acc_q + psum_q : acc_q;
      case (state_q)
         IDLE:
            if (io.start) begin
               if (io.chunk_num != '0) begin
                  acc_d       = '0;
                  remaining_d = io.chunk_num;
                  state_d     = RUN;
               end else begin
                  result_d = '0;
                  state_d  = OUT;
               end
            end
         RUN:
            if (accept) begin
               remaining_d = remaining_q - 1'b1;
               state_d     = (remaining_q == CNT_W'(1)) ? DRAIN : RUN;
            end
         // The last chunk's psum is still in flight; fold it straight into the result.
         DRAIN: begin
            result_d = acc_q + psum_q;
            state_d  = OUT;
         end
         OUT:     state_d = io.out_ready ? IDLE : OUT;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         acc_q       <= '0;
         psum_q      <= '0;
         psum_vld_q  <= 1'b0;
         result_q    <= '0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         acc_q       <= acc_d;
         psum_q      <= psum_d;
         psum_vld_q  <= psum_vld_d;
         result_q    <= result_d;
      end
   end
endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: scoreboard bench for pe_ctrl; expected dot products are queued at job start.
module tb_pe_ctrl;
   import pe_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_pass = 0;
   logic [31:0] sb [$];
   int qa [$];
   int qb [$];
   bit qv [$];
   int rdy;
   bit seen;
   bit rdy_seen;
   pe_ctrl_if #(.CNT_W(16)) io ();
   pe_ctrl #(.CNT_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk)
      if (rst_n && io.out_valid && io.out_ready) begin
         if (sb.size() == 0) check("sb_nonempty", 32'(sb.size()), 32'd1);
         else check("result", io.result, sb.pop_front());
      end
   task automatic kick(input int n);
      tick();
      io.start     = 1'b1;
      io.chunk_num = 16'(n);
      tick();
      io.start = 1'b0;
   endtask
   task automatic feed(input int a [$], input int b [$], input bit vp [$], output int nrdy);
      int idx = 0;
      nrdy = 0;
      for (int cyc = 0; cyc < 64 && idx < a.size(); cyc++) begin
         io.in_valid = (cyc < vp.size()) ? vp[cyc] : 1'b1;
         io.neuron   = {LANES{16'(a[idx])}};
         io.weight   = {LANES{16'(b[idx])}};
         @(negedge clk);
         if (io.in_ready) nrdy++;
         if (io.in_valid && io.in_ready) idx++;
         tick();
      end
      io.in_valid = 1'b0;
      check("beats", 32'(idx), 32'(a.size()));
   endtask
   task automatic job(input int a [$], input int b [$], input bit vp [$], output int nrdy);
      logic [31:0] e = '0;
      for (int i = 0; i < a.size(); i++) e += 32'(a[i] * b[i]) * 32'd32;
      sb.push_back(e);
      kick(a.size());
      feed(a, b, vp, nrdy);
      @(negedge clk);
      check("drain_ov", 32'(io.out_valid), 32'd0);
      check("drain_busy", 32'(io.busy), 32'd1);
      check("drain_rdy", 32'(io.in_ready), 32'd0);
      tick();
      @(negedge clk);
      check("lat_ov", 32'(io.out_valid), 32'd1);
      tick();
      if (io.out_ready) begin
         @(negedge clk);
         check("idle_busy", 32'(io.busy), 32'd0);
         check("idle_ov", 32'(io.out_valid), 32'd0);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      io.start = 1'b0;
      io.chunk_num = '0;
      io.in_valid = 1'b0;
      io.neuron = '0;
      io.weight = '0;
      io.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(io.busy), 32'd0);
      check("rst_rdy", 32'(io.in_ready), 32'd0);
      check("rst_ov", 32'(io.out_valid), 32'd0);
      check("rst_result", io.result, 32'd0);
      tick();
      rst_n = 1'b1;
      qa = '{2};
      qb = '{3};
      qv.delete();
      job(qa, qb, qv, rdy);
      qa = '{1, 2, 3, 4};
      qb = '{1, 1, 1, 1};
      job(qa, qb, qv, rdy);
      check("rdy_cycles", 32'(rdy), 32'd4);
      qa = '{-32768, -32768};
      qb = '{-32768, -32768};
      job(qa, qb, qv, rdy);
      qa = '{-1};
      qb = '{5};
      job(qa, qb, qv, rdy);
      qa = '{1, 1, 1};
      qb = '{1, 1, 1};
      qv = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      job(qa, qb, qv, rdy);
      check("bp_rdy_cycles", 32'(rdy), 32'd5);
      qv.delete();
      io.out_ready = 1'b0;
      qa = '{7};
      qb = '{1};
      job(qa, qb, qv, rdy);
      for (int i = 0; i < 5; i++) begin
         io.start     = (i == 1);
         io.chunk_num = 16'd3;
         @(negedge clk);
         check("hold_ov", 32'(io.out_valid), 32'd1);
         check("hold_result", io.result, 32'd224);
         tick();
      end
      io.start = 1'b0;
      io.out_ready = 1'b1;
      tick();
      @(negedge clk);
      check("post_busy", 32'(io.busy), 32'd0);
      check("post_rdy", 32'(io.in_ready), 32'd0);
      check("post_result", io.result, 32'd224);
      sb.push_back(32'd0);
      tick();
      io.start = 1'b1;
      io.chunk_num = '0;
      io.in_valid = 1'b1;
      seen = 1'b0;
      rdy_seen = 1'b0;
      for (int i = 0; i < 2 && !seen; i++) begin
         @(negedge clk);
         rdy_seen |= io.in_ready;
         seen = io.out_valid;
         tick();
         io.start = 1'b0;
      end
      io.in_valid = 1'b0;
      check("zero_ov", 32'(seen), 32'd1);
      check("zero_rdy", 32'(rdy_seen), 32'd0);
      @(negedge clk);
      check("zero_idle", 32'(io.busy), 32'd0);
      qa = '{9, 9};
      qb = '{9, 9};
      kick(4);
      feed(qa, qb, qv, rdy);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(io.busy), 32'd0);
      check("arst_rdy", 32'(io.in_ready), 32'd0);
      check("arst_ov", 32'(io.out_valid), 32'd0);
      check("arst_result", io.result, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      qa = '{4};
      qb = '{5};
      job(qa, qb, qv, rdy);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
